// File: rtl/linear_seq.sv
// linear_seq: sequencer issuing one MAC request per (row, output, input) term of y = b + x*W.
// Latency: first request the cycle after start is accepted; done the cycle after the last result is captured.
// Backpressure: counters and operand addresses hold while op_valid && !op_ready; results are never stalled.
// Build option LINEAR_SEQ_PERF_EN adds the saturating perf_cycles busy-cycle counter port.

module linear_seq #(
   parameter int INPUT_SIZE  = 4,
   parameter int OUTPUT_SIZE = 4,
   parameter int COUNT       = 1,
   localparam int IN_W  = (COUNT * INPUT_SIZE > 1)       ? $clog2(COUNT * INPUT_SIZE)       : 1,
   localparam int W_W   = (INPUT_SIZE * OUTPUT_SIZE > 1) ? $clog2(INPUT_SIZE * OUTPUT_SIZE) : 1,
   localparam int B_W   = (OUTPUT_SIZE > 1)              ? $clog2(OUTPUT_SIZE)              : 1,
   localparam int OUT_W = (COUNT * OUTPUT_SIZE > 1)      ? $clog2(COUNT * OUTPUT_SIZE)      : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [IN_W-1:0]  in_addr,
   output logic [W_W-1:0]   w_addr,
   output logic [B_W-1:0]   b_addr,
   output logic             op_valid,
   input  logic             op_ready,
   output logic             op_first,
   output logic             op_last,
   input  logic             res_valid,
   output logic             out_we,
   output logic [OUT_W-1:0] out_addr
`ifdef LINEAR_SEQ_PERF_EN
   ,
   output logic [31:0]      perf_cycles
`endif
);

   localparam int I_W   = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
   localparam int R_W   = (COUNT > 1)      ? $clog2(COUNT)      : 1;
   // result counters must be able to hold the full total, one past the last out_addr
   localparam int RES_W = $clog2(COUNT * OUTPUT_SIZE + 1);

   localparam logic [I_W-1:0]   I_LAST = I_W'(INPUT_SIZE - 1);
   localparam logic [B_W-1:0]   O_LAST = B_W'(OUTPUT_SIZE - 1);
   localparam logic [R_W-1:0]   R_LAST = R_W'(COUNT - 1);
   localparam logic [RES_W-1:0] TOTAL  = RES_W'(COUNT * OUTPUT_SIZE);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t            state;
   logic [I_W-1:0]    i_cnt;
   logic [B_W-1:0]    o_cnt;
   logic [R_W-1:0]    r_cnt;
   logic [IN_W-1:0]   in_base;   // data_in index of the current row's first input
   logic [RES_W-1:0]  iss_cnt;   // op_last requests accepted by the MAC
   logic [RES_W-1:0]  res_cnt;   // results captured
   logic [RES_W-1:0]  res_cnt_nxt;
   logic              hs;
   logic              last_hs;
   logic              final_hs;
   logic              pend;
   logic              res_take;
   logic              res_bad;
   logic              all_res;

   assign b_addr   = o_cnt;
   assign op_first = op_valid && (i_cnt == '0);
   assign op_last  = op_valid && (i_cnt == I_LAST);

   assign hs       = op_valid && op_ready;
   assign last_hs  = hs && op_last;
   assign final_hs = last_hs && (o_cnt == O_LAST) && (r_cnt == R_LAST);

   // a result is owed if an earlier op_last is unanswered or one is being accepted right now,
   // so a MAC that answers in the same cycle is not flagged as a protocol error
   assign pend        = (iss_cnt != res_cnt) || last_hs;
   assign res_take    = res_valid && busy && pend;
   assign res_bad     = res_valid && !res_take;
   assign out_we      = res_take;
   assign res_cnt_nxt = res_take ? (res_cnt + RES_W'(1)) : res_cnt;
   assign all_res     = (res_cnt_nxt == TOTAL);

   // control FSM, operand counters and result bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         op_valid <= 1'b0;
         i_cnt    <= '0;
         o_cnt    <= '0;
         r_cnt    <= '0;
         in_base  <= '0;
         in_addr  <= '0;
         w_addr   <= '0;
         iss_cnt  <= '0;
         res_cnt  <= '0;
         out_addr <= '0;
      end else begin
         if (res_take) begin
            res_cnt <= res_cnt_nxt;
            // hold on the last slot so the address never wraps inside a run
            if (res_cnt_nxt != TOTAL) begin
               out_addr <= out_addr + OUT_W'(1);
            end
         end
         if (res_bad) begin
            err <= 1'b1;
         end
         if (last_hs) begin
            iss_cnt <= iss_cnt + RES_W'(1);
         end

         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_ISSUE;
                  busy     <= 1'b1;
                  op_valid <= 1'b1;
                  err      <= res_bad;
                  i_cnt    <= '0;
                  o_cnt    <= '0;
                  r_cnt    <= '0;
                  in_base  <= '0;
                  in_addr  <= '0;
                  w_addr   <= '0;
                  iss_cnt  <= '0;
                  res_cnt  <= '0;
                  out_addr <= '0;
               end
            end

            S_ISSUE: begin
               if (final_hs) begin
                  // counters are left on the last term rather than stepping out of range
                  op_valid <= 1'b0;
                  if (all_res) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_DRAIN;
                  end
               end else if (hs) begin
                  if (i_cnt != I_LAST) begin
                     i_cnt   <= i_cnt + I_W'(1);
                     in_addr <= in_addr + IN_W'(1);
                     w_addr  <= w_addr + W_W'(OUTPUT_SIZE);
                  end else begin
                     i_cnt <= '0;
                     if (o_cnt != O_LAST) begin
                        o_cnt   <= o_cnt + B_W'(1);
                        in_addr <= in_base;
                        w_addr  <= W_W'(o_cnt) + W_W'(1);
                     end else begin
                        o_cnt   <= '0;
                        r_cnt   <= r_cnt + R_W'(1);
                        in_base <= in_base + IN_W'(INPUT_SIZE);
                        in_addr <= in_base + IN_W'(INPUT_SIZE);
                        w_addr  <= '0;
                     end
                  end
               end
            end

            S_DRAIN: begin
               if (all_res) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end

            S_DONE: begin
               state <= S_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end

            default: begin
               state    <= S_IDLE;
               busy     <= 1'b0;
               done     <= 1'b0;
               op_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef LINEAR_SEQ_PERF_EN
   // busy-cycle counter: cleared on an accepted start, saturates, holds while idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_cycles <= '0;
      end else if ((state == S_IDLE) && start) begin
         perf_cycles <= '0;
      end else if (busy && (perf_cycles != 32'hFFFF_FFFF)) begin
         perf_cycles <= perf_cycles + 32'd1;
      end
   end
`endif

endmodule
